// File: rtl/core_l1_bridge.sv
// Bridge from the core's single IO bus to the split L1I/L1D request ports.
// Decodes instruction/data space, and merges partial stores by read-modify-write.
module core_l1_bridge #(
   parameter logic [31:0] END_INST = 32'h11FD8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rw_address,
   input  logic        read_request,
   input  logic        write_request,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_strobe,
   output logic [31:0] read_data,
   output logic        read_response,
   output logic        write_response,
   output logic [31:0] addr_L1,
   output logic        read_C_L1I,
   output logic        read_C_L1D,
   output logic        write_C_L1D,
   output logic [31:0] write_data_C_L1,
   input  logic [31:0] read_data_L1I_C,
   input  logic [31:0] read_data_L1D_C,
   input  logic        ready_L1I_C,
   input  logic        ready_L1D_C,
   output logic        inst_store_err
);

   typedef enum logic [2:0] {IDLE, RD_I, RD_D, RMW_RD, WR, RESP} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] rdata_reg, rdata_next;
   logic [3:0]  strobe_reg, strobe_next;
   logic        resp_rd_reg, resp_rd_next;
   logic        err_reg, err_next;
   logic [31:0] merged_word;

   // Lanes enabled by the latched strobe come from the store, the rest from the cache word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = strobe_reg[gi] ? wdata_reg[8*gi +: 8]
                                                        : read_data_L1D_C[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         strobe_reg  <= '0;
         resp_rd_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         rdata_reg   <= rdata_next;
         strobe_reg  <= strobe_next;
         resp_rd_reg <= resp_rd_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      rdata_next     = rdata_reg;
      strobe_next    = strobe_reg;
      resp_rd_next   = resp_rd_reg;
      err_next       = err_reg;
      read_C_L1I     = 1'b0;
      read_C_L1D     = 1'b0;
      write_C_L1D    = 1'b0;
      read_response  = 1'b0;
      write_response = 1'b0;

      case (state_reg)
         IDLE: begin
            // A simultaneous read stays held by the core and is taken after this write.
            if (write_request) begin
               resp_rd_next = 1'b0;
               if (rw_address <= END_INST) begin
                  err_next   = 1'b1;
                  state_next = RESP;
               end else if (write_strobe == 4'b0000) begin
                  state_next = RESP;
               end else begin
                  addr_next   = rw_address & ~32'h3;
                  wdata_next  = write_data;
                  strobe_next = write_strobe;
                  state_next  = (write_strobe == 4'b1111) ? WR : RMW_RD;
               end
            end else if (read_request) begin
               resp_rd_next = 1'b1;
               addr_next    = rw_address & ~32'h3;
               state_next   = (rw_address <= END_INST) ? RD_I : RD_D;
            end
         end
         RD_I: begin
            read_C_L1I = 1'b1;
            if (ready_L1I_C) begin
               rdata_next = read_data_L1I_C;
               state_next = RESP;
            end
         end
         RD_D: begin
            read_C_L1D = 1'b1;
            if (ready_L1D_C) begin
               rdata_next = read_data_L1D_C;
               state_next = RESP;
            end
         end
         RMW_RD: begin
            read_C_L1D = 1'b1;
            if (ready_L1D_C) begin
               wdata_next = merged_word;
               state_next = WR;
            end
         end
         WR: begin
            write_C_L1D = 1'b1;
            if (ready_L1D_C) state_next = RESP;
         end
         RESP: begin
            read_response  = resp_rd_reg;
            write_response = !resp_rd_reg;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign addr_L1         = addr_reg;
   assign write_data_C_L1 = wdata_reg;
   assign read_data       = rdata_reg;
   assign inst_store_err  = err_reg;

endmodule

// File: tb/tb_core_l1_bridge.sv
// Directed bench for core_l1_bridge: stimulus pushes expected cache operations and
// core responses into queues; a cache responder and a response monitor pop and compare.
module tb_core_l1_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rw_address;
   logic        read_request, write_request;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic [31:0] read_data;
   logic        read_response, write_response;
   logic [31:0] addr_L1;
   logic        read_C_L1I, read_C_L1D, write_C_L1D;
   logic [31:0] write_data_C_L1;
   logic [31:0] read_data_L1I_C, read_data_L1D_C;
   logic        ready_L1I_C, ready_L1D_C;
   logic        inst_store_err;

   core_l1_bridge dut (
      .clk(clk), .rst(rst), .rw_address(rw_address),
      .read_request(read_request), .write_request(write_request),
      .write_data(write_data), .write_strobe(write_strobe),
      .read_data(read_data), .read_response(read_response),
      .write_response(write_response), .addr_L1(addr_L1),
      .read_C_L1I(read_C_L1I), .read_C_L1D(read_C_L1D),
      .write_C_L1D(write_C_L1D), .write_data_C_L1(write_data_C_L1),
      .read_data_L1I_C(read_data_L1I_C), .read_data_L1D_C(read_data_L1D_C),
      .ready_L1I_C(ready_L1I_C), .ready_L1D_C(ready_L1D_C),
      .inst_store_err(inst_store_err)
   );

   always #5 clk = ~clk;

   localparam int K_RDI = 0, K_RDD = 1, K_WR = 2;

   typedef struct {bit is_rd; logic [31:0] data;} resp_t;
   typedef struct {int kind; logic [31:0] addr; logic [31:0] data;} cop_t;

   resp_t exp_resp[$];
   cop_t  exp_cop[$];

   int n_checks = 0;
   int n_pass   = 0;
   int lat      = 1;
   int i_high   = 0;
   int last_cycles;
   logic [31:0] l1i_word = '0;
   logic [31:0] l1d_word = '0;

   task automatic chk(input bit ok, input string msg);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s", msg);
   endtask

   // Cache model: answers the single active request after 'lat' cycles.
   initial begin
      int  cnt;
      int  act;
      int  kind;
      bit  fresh;
      cop_t e;
      cnt = 0; fresh = 0;
      ready_L1I_C = 1'b0; ready_L1D_C = 1'b0;
      read_data_L1I_C = '0; read_data_L1D_C = '0;
      forever begin
         @(negedge clk);
         ready_L1I_C = 1'b0;
         ready_L1D_C = 1'b0;
         act = int'(read_C_L1I) + int'(read_C_L1D) + int'(write_C_L1D);
         if (act > 0)
            chk(act == 1, $sformatf("req_onehot got %0d active requests, required 1", act));
         if (read_C_L1I) i_high++;
         if (rst || act == 0 || fresh) begin
            cnt = 0; fresh = 0;
         end else begin
            cnt++;
            if (cnt >= lat) begin
               kind = read_C_L1I ? K_RDI : (read_C_L1D ? K_RDD : K_WR);
               if (exp_cop.size() == 0) begin
                  chk(1'b0, $sformatf("cache_op_unexpected got kind %0d addr %h, required none",
                                      kind, addr_L1));
               end else begin
                  e = exp_cop.pop_front();
                  chk(kind == e.kind && addr_L1 == e.addr,
                      $sformatf("cache_op got kind %0d addr %h, required kind %0d addr %h",
                                kind, addr_L1, e.kind, e.addr));
                  if (e.kind == K_WR)
                     chk(write_data_C_L1 == e.data,
                         $sformatf("cache_wdata got %h, required %h", write_data_C_L1, e.data));
               end
               read_data_L1I_C = l1i_word;
               read_data_L1D_C = l1d_word;
               if (kind == K_RDI) ready_L1I_C = 1'b1;
               else               ready_L1D_C = 1'b1;
               fresh = 1;
               cnt   = 0;
            end
         end
      end
   end

   // Response monitor.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (read_response || write_response) begin
            if (exp_resp.size() == 0) begin
               chk(1'b0, $sformatf("resp_unexpected got rd=%0b wr=%0b, required none",
                                   read_response, write_response));
            end else begin
               e = exp_resp.pop_front();
               chk(read_response == e.is_rd && write_response == !e.is_rd,
                   $sformatf("resp_kind got rd=%0b wr=%0b, required rd=%0b",
                             read_response, write_response, e.is_rd));
               if (e.is_rd)
                  chk(read_data == e.data,
                      $sformatf("read_data got %h, required %h", read_data, e.data));
            end
         end
      end
   end

   task automatic push_resp(input bit is_rd, input logic [31:0] d);
      resp_t r;
      r.is_rd = is_rd; r.data = d;
      exp_resp.push_back(r);
   endtask

   task automatic push_cop(input int kind, input logic [31:0] a, input logic [31:0] d);
      cop_t c;
      c.kind = kind; c.addr = a; c.data = d;
      exp_cop.push_back(c);
   endtask

   task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      int cycles;
      @(negedge clk);
      rw_address = a; write_data = d; write_strobe = s;
      read_request = do_rd; write_request = do_wr;
      cycles = 0;
      while ((read_request || write_request) && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (read_response)  read_request  = 1'b0;
         if (write_response) write_request = 1'b0;
      end
      chk(cycles < 60, $sformatf("access_timeout addr %h got %0d cycles, required < 60", a, cycles));
      read_request = 1'b0; write_request = 1'b0;
      last_cycles = cycles;
   endtask

   initial begin
      int waited;
      rst = 1'b1;
      rw_address = '0; read_request = 1'b0; write_request = 1'b0;
      write_data = '0; write_strobe = '0;
      repeat (3) @(negedge clk);
      chk({read_response, write_response, read_C_L1I, read_C_L1D, write_C_L1D, inst_store_err} == 6'b0,
          "reset_ctrl got nonzero control outputs, required all 0");
      chk(addr_L1 == 32'h0 && write_data_C_L1 == 32'h0,
          $sformatf("reset_bus got addr %h wdata %h, required 0", addr_L1, write_data_C_L1));
      chk(read_data == 32'h0, $sformatf("reset_rdata got %h, required 0", read_data));
      rst = 1'b0;

      // Instruction read, ready after 3 cycles.
      lat = 3; l1i_word = 32'h00000013; i_high = 0;
      push_cop(K_RDI, 32'h000100D8, '0); push_resp(1, 32'h00000013);
      access(1, 0, 32'h000100D8, '0, '0);
      chk(i_high == 3, $sformatf("l1i_req_cycles got %0d, required 3", i_high));

      // Data read.
      lat = 1; l1d_word = 32'hDEADBEEF;
      push_cop(K_RDD, 32'h00020000, '0); push_resp(1, 32'hDEADBEEF);
      access(1, 0, 32'h00020000, '0, '0);

      // Partial store, single lane.
      lat = 2; l1d_word = 32'h11223344;
      push_cop(K_RDD, 32'h00020000, '0); push_cop(K_WR, 32'h00020000, 32'h11AB3344);
      push_resp(0, '0);
      access(0, 1, 32'h00020002, 32'h00AB0000, 4'b0100);
      chk(read_data == 32'hDEADBEEF, $sformatf("rdata_hold got %h, required deadbeef", read_data));

      // Partial store, outer lanes.
      lat = 1; l1d_word = 32'hAABBCCDD;
      push_cop(K_RDD, 32'h00020000, '0); push_cop(K_WR, 32'h00020000, 32'h11BBCC22);
      push_resp(0, '0);
      access(0, 1, 32'h00020001, 32'h11000022, 4'b1001);

      // Empty strobe: response only.
      push_resp(0, '0);
      access(0, 1, 32'h00020010, 32'hFFFFFFFF, 4'b0000);

      // Region boundary.
      l1i_word = 32'h0000006F;
      push_cop(K_RDI, 32'h00011FD8, '0); push_resp(1, 32'h0000006F);
      access(1, 0, 32'h00011FD8, '0, '0);
      l1d_word = 32'h12345678;
      push_cop(K_RDD, 32'h00011FDC, '0); push_resp(1, 32'h12345678);
      access(1, 0, 32'h00011FDC, '0, '0);

      // Store into instruction space.
      push_resp(0, '0);
      access(0, 1, 32'h00010100, 32'h12345678, 4'b1111);
      chk(last_cycles <= 2, $sformatf("inst_store_latency got %0d, required <= 2", last_cycles));
      chk(inst_store_err == 1'b1, $sformatf("inst_store_err got %0b, required 1", inst_store_err));

      // Simultaneous write and read: write first, data unchanged.
      l1d_word = 32'h55AA55AA;
      push_cop(K_WR, 32'h00020000, 32'hCAFEF00D); push_resp(0, '0);
      push_cop(K_RDD, 32'h00020000, '0);         push_resp(1, 32'h55AA55AA);
      access(1, 1, 32'h00020000, 32'hCAFEF00D, 4'b1111);
      chk(inst_store_err == 1'b1, $sformatf("err_sticky got %0b, required 1", inst_store_err));

      // Reset while WR is waiting on the cache.
      lat = 20;
      @(negedge clk);
      rw_address = 32'h00020004; write_data = 32'h0F0F0F0F; write_strobe = 4'b1111;
      write_request = 1'b1;
      waited = 0;
      while (!write_C_L1D && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk(write_C_L1D == 1'b1, $sformatf("wr_reached got %0b, required 1", write_C_L1D));
      rst = 1'b1;
      @(negedge clk);
      chk({read_response, write_response, read_C_L1I, read_C_L1D, write_C_L1D, inst_store_err} == 6'b0,
          "rst_mid_ctrl got nonzero control outputs, required all 0");
      chk(addr_L1 == 32'h0 && write_data_C_L1 == 32'h0 && read_data == 32'h0,
          $sformatf("rst_mid_bus got addr %h wdata %h rdata %h, required 0",
                    addr_L1, write_data_C_L1, read_data));
      write_request = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Normal operation after reset.
      lat = 1; l1d_word = 32'h0BADC0DE;
      push_cop(K_RDD, 32'h00020008, '0); push_resp(1, 32'h0BADC0DE);
      access(1, 0, 32'h00020008, '0, '0);

      repeat (4) @(negedge clk);
      chk(exp_resp.size() == 0, $sformatf("resp_queue_left got %0d, required 0", exp_resp.size()));
      chk(exp_cop.size() == 0, $sformatf("cache_queue_left got %0d, required 0", exp_cop.size()));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish, required finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/core_l1_bridge.md
# core_l1_bridge

Registered bridge between the RISC-V core's single IO bus and the split L1I/L1D cache ports of the cache hierarchy. Decodes each core access by address into an instruction-region read, data-region read, or data-region write, and drives the matching cache request until the cache signals ready. Performs byte-lane read-modify-write for partial stores, since L1D accepts only full 32-bit words. Returns a one-cycle response pulse with registered data to the core.

## Interface
- END_INST, 32'h11FD8, last word address of the instruction region; addresses <= END_INST are instruction space, > END_INST are data space.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- rw_address  in  32  core access address; byte offset bits [1:0] ignored for cache addressing.
- read_request  in  1  core read request, held until read_response.
- write_request  in  1  core write request, held until write_response.
- write_data  in  32  core store data, lane-aligned.
- write_strobe  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- read_data  out  32  registered read word to core.
- read_response  out  1  one-cycle pulse, read complete.
- write_response  out  1  one-cycle pulse, write complete.
- addr_L1  out  32  registered address to both L1 caches, [1:0] forced to 0.
- read_C_L1I  out  1  read request to L1I.
- read_C_L1D  out  1  read request to L1D.
- write_C_L1D  out  1  write request to L1D.
- write_data_C_L1  out  32  merged full-word store data to L1D.
- read_data_L1I_C  in  32  L1I read word, valid when ready_L1I_C.
- read_data_L1D_C  in  32  L1D read word, valid when ready_L1D_C.
- ready_L1I_C  in  1  L1I read complete.
- ready_L1D_C  in  1  L1D read or write complete.
- inst_store_err  out  1  sticky flag: a store targeted the instruction region.

## Operation
- States: IDLE, RD_I, RD_D, RMW_RD, WR, RESP.
- IDLE: requests sampled only here. write_request has priority over read_request on the same cycle; the read stays pending, because the core holds it, and is taken after RESP.
- Read, addr <= END_INST: latch address, go RD_I, assert read_C_L1I.
- Read, addr > END_INST: latch address, go RD_D, assert read_C_L1D.
- Write, addr <= END_INST: no cache access. Set inst_store_err, go RESP with write_response.
- Write, strobe == 4'b0000: no cache access, go RESP with write_response.
- Write, strobe == 4'b1111: latch address and data, go WR with write_data_C_L1 = write_data.
- Write, any other strobe: latch address, data and strobe, go RMW_RD, assert read_C_L1D.
- RD_I / RD_D: hold the request high until the matching ready is sampled high. Capture the cache word into read_data, drop the request, go RESP with read_response.
- RMW_RD: on ready_L1D_C, merge per lane. Lane i takes write_data when strobe[i] is set, otherwise read_data_L1D_C. Go WR.
- WR: hold write_C_L1D high with the merged word until ready_L1D_C, then go RESP with write_response.
- RESP: pulse the selected response for exactly one cycle, then return to IDLE.
- Requests arriving in any non-IDLE state are not queued.
- Address, data and strobe are latched at acceptance. Core-side changes after acceptance do not affect the access in flight.

## Timing
- Reset: all outputs 0, state IDLE, inst_store_err cleared.
- Reset mid-access: the outstanding cache request drops on the next edge and no response is issued.
- Acceptance at edge T. addr_L1 and the cache request are valid from T+1.
- Cache ready sampled at edge R. The request is low after R.
- read_response and read_data are valid in cycle R+1. Minimum read latency core-to-response is 2 cycles.
- read_data holds its value until the next read completes.
- A partial write takes two cache handshakes. write_C_L1D rises the cycle after the RMW ready.
- Back-to-back accesses: at least one IDLE cycle follows each RESP.
- A ready arriving while no request is pending is ignored.

## Test plan
- Read at 0x100D8, L1I ready 3 cycles later returning 0x00000013: read_C_L1I high for 3 cycles, addr_L1 = 0x100D8, read_response pulses once with read_data = 0x00000013. read_C_L1D never asserted.
- Read at 0x20000 with 0xDEADBEEF from L1D: only read_C_L1D asserted; response returns 0xDEADBEEF.
- Store at 0x20002, strobe 4'b0100, data 0x00AB0000, old word 0x11223344: read_C_L1D, then write_C_L1D with 0x11AB3344; a single write_response.
- Store at 0x10100, any strobe: no cache request, write_response within 2 cycles, inst_store_err = 1 and it stays set.
- Read and write asserted together at 0x20000, strobe 4'b1111: write served first with data unchanged, then the read; 2 response pulses.
- rst asserted while in WR: next cycle all outputs 0 and no write_response pulse.
